// File: rtl/rast_pkg.sv
// Shared rasteriser types: stencil compare functions, update ops,
// and the stencil stage FSM state.
package rast_pkg;

  typedef enum logic [2:0] {
    SF_NEVER    = 3'd0,
    SF_LESS     = 3'd1,
    SF_LEQUAL   = 3'd2,
    SF_GREATER  = 3'd3,
    SF_GEQUAL   = 3'd4,
    SF_EQUAL    = 3'd5,
    SF_NOTEQUAL = 3'd6,
    SF_ALWAYS   = 3'd7
  } stencil_func_t;

  typedef enum logic [2:0] {
    SO_KEEP      = 3'd0,
    SO_ZERO      = 3'd1,
    SO_REPLACE   = 3'd2,
    SO_INCR      = 3'd3,
    SO_INCR_WRAP = 3'd4,
    SO_DECR      = 3'd5,
    SO_DECR_WRAP = 3'd6,
    SO_INVERT    = 3'd7
  } stencil_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_RESP  = 3'd3,
    ST_CLEAR = 3'd4
  } stencil_state_t;

endpackage

// File: rtl/stencil_ram.sv
// Single-port per-pixel stencil store, one-cycle read latency,
// read-first on a write cycle.
module stencil_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 1280 * 720,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we)
        mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/stencil_test_unit.sv
// Stencil stage: masked compare of ref against the stored value,
// read-modify-write update, and bulk clear of the stencil store.
import rast_pkg::*;

module stencil_test_unit #(
  parameter int STENCIL_W = 8,
  parameter int X_RES     = 1280,
  parameter int Y_RES     = 720,
  parameter int ADDR_W    = $clog2(X_RES * Y_RES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 frag_valid_i,
  output logic                 frag_ready_o,
  input  logic [10:0]          frag_x_i,
  input  logic [9:0]           frag_y_i,
  input  logic                 depth_pass_i,
  input  logic [STENCIL_W-1:0] ref_val_i,
  input  logic [2:0]           func_i,
  input  logic [STENCIL_W-1:0] read_mask_i,
  input  logic [STENCIL_W-1:0] write_mask_i,
  input  logic [2:0]           sfail_op_i,
  input  logic [2:0]           dpfail_op_i,
  input  logic [2:0]           dppass_op_i,
  input  logic                 clear_i,
  input  logic [STENCIL_W-1:0] clear_val_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic                 stencil_pass_o,
  output logic                 frag_pass_o,
  output logic                 busy_o
);

  localparam int DEPTH = X_RES * Y_RES;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  stencil_state_t      state;
  logic [ADDR_W-1:0]   addr_q;
  logic                depth_q;
  logic [STENCIL_W-1:0] ref_q;
  logic [STENCIL_W-1:0] rmask_q;
  logic [STENCIL_W-1:0] wmask_q;
  logic [STENCIL_W-1:0] old_q;
  logic [STENCIL_W-1:0] clr_val_q;
  stencil_func_t       func_q;
  stencil_op_t         sfail_q;
  stencil_op_t         dpfail_q;
  stencil_op_t         dppass_q;

  logic                in_range;
  logic [ADDR_W-1:0]   frag_addr;
  logic [STENCIL_W-1:0] cmp_a;
  logic [STENCIL_W-1:0] cmp_b;
  logic                cmp_pass;
  stencil_op_t         op_sel;
  logic [STENCIL_W-1:0] op_res;
  logic [STENCIL_W-1:0] new_val;

  logic                ram_en;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [STENCIL_W-1:0] ram_wdata;
  logic [STENCIL_W-1:0] ram_rdata;

  assign in_range = (int'(frag_x_i) < X_RES) &&
                    (int'(frag_y_i) < Y_RES);
  assign frag_addr = ADDR_W'(frag_y_i) * ADDR_W'(X_RES)
                   + ADDR_W'(frag_x_i);

  assign frag_ready_o = (state == ST_IDLE) && !clear_i;
  assign busy_o       = (state != ST_IDLE);

  assign cmp_a = ref_q & rmask_q;
  assign cmp_b = old_q & rmask_q;

  always_comb begin
    cmp_pass = 1'b0;
    unique case (func_q)
      SF_NEVER:    cmp_pass = 1'b0;
      SF_LESS:     cmp_pass = cmp_a <  cmp_b;
      SF_LEQUAL:   cmp_pass = cmp_a <= cmp_b;
      SF_GREATER:  cmp_pass = cmp_a >  cmp_b;
      SF_GEQUAL:   cmp_pass = cmp_a >= cmp_b;
      SF_EQUAL:    cmp_pass = cmp_a == cmp_b;
      SF_NOTEQUAL: cmp_pass = cmp_a != cmp_b;
      SF_ALWAYS:   cmp_pass = 1'b1;
      default:     cmp_pass = 1'b0;
    endcase
  end

  always_comb begin
    op_sel = dppass_q;
    unique case (1'b1)
      !cmp_pass:            op_sel = sfail_q;
      cmp_pass && !depth_q: op_sel = dpfail_q;
      cmp_pass && depth_q:  op_sel = dppass_q;
      default:              op_sel = dppass_q;
    endcase
  end

  always_comb begin
    op_res = old_q;
    unique case (op_sel)
      SO_KEEP:      op_res = old_q;
      SO_ZERO:      op_res = '0;
      SO_REPLACE:   op_res = ref_q;
      SO_INCR:      op_res = (&old_q) ? old_q
                                      : old_q + STENCIL_W'(1);
      SO_INCR_WRAP: op_res = old_q + STENCIL_W'(1);
      SO_DECR:      op_res = (old_q == '0) ? old_q
                                           : old_q - STENCIL_W'(1);
      SO_DECR_WRAP: op_res = old_q - STENCIL_W'(1);
      SO_INVERT:    op_res = ~old_q;
      default:      op_res = old_q;
    endcase
  end

  assign new_val = (old_q & ~wmask_q) | (op_res & wmask_q);

  // Gating with rst_i drops any write in the reset cycle.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = new_val;
    if (!rst_i) begin
      unique case (state)
        ST_IDLE: begin
          if (!clear_i && frag_valid_i && in_range) begin
            ram_en   = 1'b1;
            ram_addr = frag_addr;
          end
        end
        ST_EXEC: begin
          if (new_val != old_q) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
          end
        end
        ST_CLEAR: begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_wdata = clr_val_q;
        end
        default: ;
      endcase
    end
  end

  stencil_ram #(
    .W     (STENCIL_W),
    .DEPTH (DEPTH),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk_i),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      addr_q         <= '0;
      res_valid_o    <= 1'b0;
      stencil_pass_o <= 1'b0;
      frag_pass_o    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (clear_i) begin
            state     <= ST_CLEAR;
            addr_q    <= '0;
            clr_val_q <= clear_val_i;
          end else if (frag_valid_i) begin
            addr_q   <= frag_addr;
            depth_q  <= depth_pass_i;
            ref_q    <= ref_val_i;
            func_q   <= stencil_func_t'(func_i);
            rmask_q  <= read_mask_i;
            wmask_q  <= write_mask_i;
            sfail_q  <= stencil_op_t'(sfail_op_i);
            dpfail_q <= stencil_op_t'(dpfail_op_i);
            dppass_q <= stencil_op_t'(dppass_op_i);
            if (in_range) begin
              state <= ST_READ;
            end else begin
              state          <= ST_RESP;
              res_valid_o    <= 1'b1;
              stencil_pass_o <= 1'b0;
              frag_pass_o    <= 1'b0;
            end
          end
        end
        ST_READ: begin
          old_q <= ram_rdata;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          stencil_pass_o <= cmp_pass;
          frag_pass_o    <= cmp_pass && depth_q;
          res_valid_o    <= 1'b1;
          state          <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready_i) begin
            res_valid_o    <= 1'b0;
            stencil_pass_o <= 1'b0;
            frag_pass_o    <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (addr_q == LAST)
            state <= ST_IDLE;
          else
            addr_q <= addr_q + ADDR_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stencil_test_unit.sv
// Directed bench for stencil_test_unit on a reduced 16x8 surface.
import rast_pkg::*;

module tb_stencil_test_unit;

  localparam int XR = 16;
  localparam int YR = 8;
  localparam int N  = XR * YR;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       frag_valid_i;
  logic       frag_ready_o;
  logic [10:0] frag_x_i;
  logic [9:0] frag_y_i;
  logic       depth_pass_i;
  logic [7:0] ref_val_i;
  logic [2:0] func_i;
  logic [7:0] read_mask_i;
  logic [7:0] write_mask_i;
  logic [2:0] sfail_op_i;
  logic [2:0] dpfail_op_i;
  logic [2:0] dppass_op_i;
  logic       clear_i;
  logic [7:0] clear_val_i;
  logic       res_valid_o;
  logic       res_ready_i;
  logic       stencil_pass_o;
  logic       frag_pass_o;
  logic       busy_o;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (dut.ram_en) en_cnt++;

  stencil_test_unit #(
    .STENCIL_W (8),
    .X_RES     (XR),
    .Y_RES     (YR)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .frag_valid_i   (frag_valid_i),
    .frag_ready_o   (frag_ready_o),
    .frag_x_i       (frag_x_i),
    .frag_y_i       (frag_y_i),
    .depth_pass_i   (depth_pass_i),
    .ref_val_i      (ref_val_i),
    .func_i         (func_i),
    .read_mask_i    (read_mask_i),
    .write_mask_i   (write_mask_i),
    .sfail_op_i     (sfail_op_i),
    .dpfail_op_i    (dpfail_op_i),
    .dppass_op_i    (dppass_op_i),
    .clear_i        (clear_i),
    .clear_val_i    (clear_val_i),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready_i),
    .stencil_pass_o (stencil_pass_o),
    .frag_pass_o    (frag_pass_o),
    .busy_o         (busy_o)
  );

  // Drives one fragment; scrambles the inputs right after accept
  // so only the latched copies can produce the right answer.
  task automatic run_frag(
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        dp,
    input  logic [7:0]  rf,
    input  logic [2:0]  fn,
    input  logic [7:0]  rm,
    input  logic [7:0]  wm,
    input  logic [2:0]  sf,
    input  logic [2:0]  df,
    input  logic [2:0]  pp,
    output int          lat,
    output logic        sp,
    output logic        fp
  );
    int w;
    @(negedge clk);
    frag_x_i = x; frag_y_i = y; depth_pass_i = dp;
    ref_val_i = rf; func_i = fn;
    read_mask_i = rm; write_mask_i = wm;
    sfail_op_i = sf; dpfail_op_i = df; dppass_op_i = pp;
    frag_valid_i = 1'b1;
    w = 0;
    while (!frag_ready_o && w < 300) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    frag_valid_i = 1'b0;
    depth_pass_i = ~dp; ref_val_i = ~rf; func_i = ~fn;
    read_mask_i = ~rm; write_mask_i = ~wm;
    sfail_op_i = ~sf; dpfail_op_i = ~df; dppass_op_i = ~pp;
    lat = 1;
    while (!res_valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!res_valid_o) lat = -1;
    sp = stencil_pass_o;
    fp = frag_pass_o;
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
  endtask

  task automatic set_val(
    input logic [10:0] x,
    input logic [9:0]  y,
    input logic [7:0]  v
  );
    int l;
    logic s, f;
    run_frag(x, y, 1'b1, v, SF_ALWAYS, 8'hFF, 8'hFF,
             SO_KEEP, SO_KEEP, SO_REPLACE, l, s, f);
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    frag_valid_i = 1'b0; res_ready_i = 1'b0;
    clear_i = 1'b0; clear_val_i = '0;
    frag_x_i = '0; frag_y_i = '0; depth_pass_i = 1'b0;
    ref_val_i = '0; func_i = '0;
    read_mask_i = '0; write_mask_i = '0;
    sfail_op_i = '0; dpfail_op_i = '0; dppass_op_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset res_valid got=%b exp=0", res_valid_o);
    end
    checks++;
    if (stencil_pass_o !== 1'b0) begin
      errors++; $display("FAIL reset stencil_pass got=%b exp=0", stencil_pass_o);
    end
    checks++;
    if (frag_pass_o !== 1'b0) begin
      errors++; $display("FAIL reset frag_pass got=%b exp=0", frag_pass_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL reset busy got=%b exp=0", busy_o);
    end
    checks++;
    if (frag_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset frag_ready got=%b exp=1", frag_ready_o);
    end
  endtask

  task automatic test_clear_eq_incr;
    int cnt, lat;
    logic sp, fp;
    @(negedge clk);
    clear_i = 1'b1; clear_val_i = 8'h05;
    @(negedge clk);
    clear_i = 1'b0; clear_val_i = 8'hEE;
    cnt = 0;
    while (busy_o && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt !== N) begin
      errors++; $display("FAIL clear_cycles got=%0d exp=%0d", cnt, N);
    end
    checks++;
    if (dut.u_ram.mem[0] !== 8'h05 || dut.u_ram.mem[N-1] !== 8'h05) begin
      errors++;
      $display("FAIL clear_fill got=%h/%h exp=05/05",
               dut.u_ram.mem[0], dut.u_ram.mem[N-1]);
    end
    run_frag(11'd3, 10'd2, 1'b1, 8'h05, SF_EQUAL, 8'hFF, 8'hFF,
             SO_KEEP, SO_KEEP, SO_INCR, lat, sp, fp);
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL eq_latency got=%0d exp=3", lat);
    end
    checks++;
    if (sp !== 1'b1 || fp !== 1'b1) begin
      errors++; $display("FAIL eq_pass got=%b%b exp=11", sp, fp);
    end
    checks++;
    if (dut.u_ram.mem[2*XR+3] !== 8'h06) begin
      errors++; $display("FAIL eq_incr got=%h exp=06", dut.u_ram.mem[2*XR+3]);
    end
  endtask

  task automatic test_saturate;
    int lat;
    logic sp, fp;
    logic [2:0] ops [4];
    logic [7:0] init [4];
    logic [7:0] expv [4];
    ops  = '{SO_INCR, SO_INCR_WRAP, SO_DECR, SO_DECR_WRAP};
    init = '{8'hFF, 8'hFF, 8'h00, 8'h00};
    expv = '{8'hFF, 8'h00, 8'h00, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      set_val(11'd1, 10'd1, init[i]);
      run_frag(11'd1, 10'd1, 1'b1, 8'h00, SF_ALWAYS, 8'hFF, 8'hFF,
               SO_KEEP, SO_KEEP, ops[i], lat, sp, fp);
      checks++;
      if (dut.u_ram.mem[XR+1] !== expv[i]) begin
        errors++;
        $display("FAIL sat_op%0d got=%h exp=%h", i, dut.u_ram.mem[XR+1], expv[i]);
      end
    end
  endtask

  task automatic test_masked_less;
    int lat;
    logic sp, fp;
    set_val(11'd2, 10'd3, 8'h3C);
    run_frag(11'd2, 10'd3, 1'b1, 8'h0C, SF_LESS, 8'h0F, 8'hF0,
             SO_INVERT, SO_KEEP, SO_KEEP, lat, sp, fp);
    checks++;
    if (sp !== 1'b0 || fp !== 1'b0) begin
      errors++; $display("FAIL less_pass got=%b%b exp=00", sp, fp);
    end
    checks++;
    if (dut.u_ram.mem[3*XR+2] !== 8'hCC) begin
      errors++; $display("FAIL less_invert got=%h exp=cc", dut.u_ram.mem[3*XR+2]);
    end
  endtask

  task automatic test_depth_fail;
    int lat;
    logic sp, fp;
    set_val(11'd4, 10'd4, 8'h77);
    run_frag(11'd4, 10'd4, 1'b0, 8'h77, SF_EQUAL, 8'hFF, 8'hFF,
             SO_KEEP, SO_ZERO, SO_REPLACE, lat, sp, fp);
    checks++;
    if (sp !== 1'b1 || fp !== 1'b0) begin
      errors++; $display("FAIL dpfail_pass got=%b%b exp=10", sp, fp);
    end
    checks++;
    if (dut.u_ram.mem[4*XR+4] !== 8'h00) begin
      errors++; $display("FAIL dpfail_zero got=%h exp=00", dut.u_ram.mem[4*XR+4]);
    end
  endtask

  task automatic test_out_of_range;
    int e0, lat;
    logic sp, fp;
    e0 = en_cnt;
    @(negedge clk);
    frag_x_i = 11'd1280; frag_y_i = 10'd0; depth_pass_i = 1'b1;
    ref_val_i = 8'h00; func_i = SF_ALWAYS;
    read_mask_i = 8'hFF; write_mask_i = 8'hFF;
    sfail_op_i = SO_ZERO; dpfail_op_i = SO_ZERO; dppass_op_i = SO_ZERO;
    frag_valid_i = 1'b1;
    @(negedge clk);
    frag_valid_i = 1'b0;
    checks++;
    if (res_valid_o !== 1'b1 || stencil_pass_o !== 1'b0) begin
      errors++;
      $display("FAIL oor_immediate got=%b%b exp=10", res_valid_o, stencil_pass_o);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid_o !== 1'b1 || stencil_pass_o !== 1'b0 ||
          frag_pass_o !== 1'b0 || frag_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL oor_hold%0d got=%b%b%b%b exp=1000", i, res_valid_o,
                 stencil_pass_o, frag_pass_o, frag_ready_o);
      end
    end
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
    checks++;
    if (frag_ready_o !== 1'b1 || res_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL oor_release got=%b%b exp=10", frag_ready_o, res_valid_o);
    end
    run_frag(11'd16, 10'd0, 1'b1, 8'h00, SF_ALWAYS, 8'hFF, 8'hFF,
             SO_ZERO, SO_ZERO, SO_ZERO, lat, sp, fp);
    checks++;
    if (lat !== 1 || sp !== 1'b0) begin
      errors++; $display("FAIL oor_x_edge got=%0d/%b exp=1/0", lat, sp);
    end
    run_frag(11'd0, 10'd8, 1'b1, 8'h00, SF_ALWAYS, 8'hFF, 8'hFF,
             SO_ZERO, SO_ZERO, SO_ZERO, lat, sp, fp);
    checks++;
    if (lat !== 1 || fp !== 1'b0) begin
      errors++; $display("FAIL oor_y_edge got=%0d/%b exp=1/0", lat, fp);
    end
    checks++;
    if (en_cnt !== e0) begin
      errors++; $display("FAIL oor_no_access got=%0d exp=%0d", en_cnt, e0);
    end
  endtask

  task automatic test_clear_priority;
    int cnt, lat, e0;
    @(negedge clk);
    clear_i = 1'b1; clear_val_i = 8'h33;
    frag_x_i = 11'd5; frag_y_i = 10'd1; depth_pass_i = 1'b1;
    ref_val_i = 8'h33; func_i = SF_EQUAL;
    read_mask_i = 8'hFF; write_mask_i = 8'hFF;
    sfail_op_i = SO_KEEP; dpfail_op_i = SO_KEEP; dppass_op_i = SO_KEEP;
    frag_valid_i = 1'b1;
    #1;
    checks++;
    if (frag_ready_o !== 1'b0) begin
      errors++; $display("FAIL prio_ready got=%b exp=0", frag_ready_o);
    end
    @(negedge clk);
    clear_i = 1'b0;
    cnt = 0;
    while (busy_o && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt !== N || frag_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL prio_wait got=%0d/%b exp=%0d/1", cnt, frag_ready_o, N);
    end
    e0 = en_cnt;
    @(negedge clk);
    frag_valid_i = 1'b0;
    lat = 1;
    while (!res_valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 3 || stencil_pass_o !== 1'b1) begin
      errors++;
      $display("FAIL prio_frag got=%0d/%b exp=3/1", lat, stencil_pass_o);
    end
    checks++;
    if (en_cnt - e0 !== 1) begin
      errors++; $display("FAIL keep_no_write got=%0d exp=1", en_cnt - e0);
    end
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_clear;
    @(negedge clk);
    clear_i = 1'b1; clear_val_i = 8'hAA;
    @(negedge clk);
    clear_i = 1'b0;
    repeat (10) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || res_valid_o !== 1'b0 || frag_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_clear got=%b%b%b exp=001",
               busy_o, res_valid_o, frag_ready_o);
    end
    rst_i = 1'b0;
    repeat (N + 5) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || dut.u_ram.mem[0] !== 8'hAA ||
        dut.u_ram.mem[N-1] !== 8'h33) begin
      errors++;
      $display("FAIL rst_partial got=%b/%h/%h exp=0/aa/33", busy_o,
               dut.u_ram.mem[0], dut.u_ram.mem[N-1]);
    end
  endtask

  initial begin
    test_reset();
    test_clear_eq_incr();
    test_saturate();
    test_masked_less();
    test_depth_fail();
    test_out_of_range();
    test_clear_priority();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stencil_test_unit.md
Name: stencil_test_unit

Overview:
- Second-generation stencil stage between alpha test and depth-write commit in the rasteriser.
- Owns a per-pixel stencil store, STENCIL_W bits wide.
- Performs the masked GL stencil compare of the reference against the stored value. Applies the GL sfail/dpfail/dppass update ops via a read-modify-write with a write mask.
- Supports a bulk clear and valid/ready handshakes on both the input and result sides.

Parameters:
- STENCIL_W, 8: stencil bits per pixel.
- X_RES, 1280: horizontal resolution.
- Y_RES, 720: vertical resolution.
- ADDR_W, $clog2(X_RES*Y_RES): store address width (derived; do not override).

Ports:
- clk_i in 1: clock
- rst_i in 1: synchronous active-high reset
- frag_valid_i in 1: fragment request valid
- frag_ready_o out 1: unit accepts a fragment this cycle
- frag_x_i in 11: pixel x
- frag_y_i in 10: pixel y
- depth_pass_i in 1: depth test result for this fragment, from the parallel depth unit
- ref_val_i in STENCIL_W: stencil reference
- func_i in 3: compare function (stencil_func_t)
- read_mask_i in STENCIL_W: compare mask
- write_mask_i in STENCIL_W: update mask
- sfail_op_i, dpfail_op_i, dppass_op_i in 3 each: stencil_op_t for each outcome
- clear_i in 1: start bulk clear (sampled only in IDLE)
- clear_val_i in STENCIL_W: clear value
- res_valid_o out 1: result valid
- res_ready_i in 1: downstream accepts result
- stencil_pass_o out 1: compare passed
- frag_pass_o out 1: stencil_pass AND depth_pass; the fragment survives
- busy_o out 1: state != IDLE

Behaviour:
- Reset state: IDLE. res_valid_o, stencil_pass_o, frag_pass_o, busy_o all 0. frag_ready_o = 1 in IDLE. Stored contents are not reset.
- The FSM is non-pipelined: at most one fragment in flight, so there is no read-after-write hazard.
- IDLE:
  - clear_i=1 takes priority over frag_valid_i: go to CLEAR with address counter = 0. frag_ready_o = 0 that cycle.
  - Otherwise, frag_valid_i && frag_ready_o is the accept. Latch x, y, depth_pass, ref, func, masks and ops. Issue the store read at addr = y*X_RES + x. Go to READ.
- READ: the store has 1-cycle read latency and data is captured here. Go to EXEC.
- EXEC:
  - Compare: A = ref & rmask, B = stored & rmask.
  - Pass conditions by function: NEVER 0; LESS A<B; LEQUAL A<=B; GREATER A>B; GEQUAL A>=B; EQUAL A==B; NOTEQUAL A!=B; ALWAYS 1. All comparisons are unsigned.
  - Select op: sfail_op if compare fails; dpfail_op if compare passes and depth fails; dppass_op if both pass.
  - Op results:
    - KEEP: old
    - ZERO: 0
    - REPLACE: ref
    - INCR: saturate at all-ones
    - INCR_WRAP: +1 mod 2^STENCIL_W
    - DECR: saturate at 0
    - DECR_WRAP: -1 mod 2^STENCIL_W
    - INVERT: ~old
  - Write new = (old & ~wmask) | (op_result & wmask). The write is issued only if new != old.
  - Register the result outputs and go to RESP.
- RESP: res_valid_o = 1. Outputs hold stable until res_ready_i. On that handshake, go to IDLE. Accept-to-result latency is 3 cycles minimum.
- Out-of-range fragment (x >= X_RES or y >= Y_RES):
  - No read and no write.
  - Go directly from accept to RESP with stencil_pass_o = 0 and frag_pass_o = 0.
- CLEAR:
  - Write clear_val_i unmasked to one address per cycle, from 0 to X_RES*Y_RES-1.
  - On the last address, go to IDLE.
  - A clear takes X_RES*Y_RES cycles. clear_i is ignored outside IDLE.
- rst_i asserted in any state: next cycle is IDLE with outputs at reset values. Any in-flight write is abandoned; a partially-written clear is not completed.
- func_i and op inputs are used only as latched at accept. Changes mid-operation have no effect.

Decomposition:
- Package rast_pkg holds:
  - stencil_func_t, with the encoding shared with the depth unit: NEVER 0, LESS 1, LEQUAL 2, GREATER 3, GEQUAL 4, EQUAL 5, NOTEQUAL 6, ALWAYS 7.
  - stencil_op_t: KEEP 0, ZERO 1, REPLACE 2, INCR 3, INCR_WRAP 4, DECR 5, DECR_WRAP 6, INVERT 7.
  - The FSM state enum.
- Sub-module stencil_ram: single-port synchronous RAM, X_RES*Y_RES words of STENCIL_W bits, 1-cycle read latency, write-enable. Inferable as block RAM.

Test Plan:
- Clear with clear_val=0x05, then fragment (3,2), func=EQUAL, ref=0x05, masks=0xFF, depth_pass=1, dppass_op=INCR -> pass=1, frag_pass=1, stored(3,2)=0x06, result 3 cycles after accept.
- Stored 0xFF, INCR vs INCR_WRAP as dppass_op, ALWAYS -> stored 0xFF and 0x00 respectively. Stored 0x00 with DECR / DECR_WRAP -> 0x00 and 0xFF.
- Stored 0x3C, ref 0x0C, read_mask 0x0F, LESS -> A=0x0C, B=0x0C, fail. sfail_op=INVERT, write_mask=0xF0 -> stored 0xCC.
- Compare pass with depth_pass=0: dpfail_op=ZERO and dppass_op=REPLACE -> stored 0, stencil_pass=1, frag_pass=0.
- Fragment x=1280 -> immediate result pass=0 and no store access. Hold res_ready_i=0 for 5 cycles -> outputs stable and frag_ready_o=0 throughout.
- clear_i and frag_valid_i asserted in the same IDLE cycle -> the clear runs first and the fragment is accepted after X_RES*Y_RES cycles. Assert rst_i mid-clear -> IDLE next cycle, busy_o=0.
